// File: rtl/tx_packetizer_pkg.sv
// Shared definitions for the TX frame assembler: state encoding, header size and
// the mode constants also used by the upstream data source.
package tx_packetizer_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PREAMBLE = 3'd1;
  localparam logic [2:0] HEADER   = 3'd2;
  localparam logic [2:0] PAYLOAD  = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = IDLE,
    StPreamble = PREAMBLE,
    StHeader   = HEADER,
    StPayload  = PAYLOAD,
    StGap      = GAP
  } tx_state_e;

  localparam int unsigned HDR_LEN = 16;

  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;

  // Payload symbol count: one bit per BPSK symbol, two per QPSK symbol (floor).
  function automatic logic [15:0] calc_nsym(input logic bpsk, input logic [15:0] len_bits);
    return bpsk ? len_bits : {1'b0, len_bits[15:1]};
  endfunction

endpackage

// File: rtl/tx_frame_bit_shifter.sv
// Loadable MSB-first shift register with a remaining-bit counter; serialises the
// preamble and header bit streams.
module tx_frame_bit_shifter #(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_data,
  input  logic [CntW-1:0]  i_count,
  input  logic             i_shift,
  output logic             o_bit,
  output logic             o_last,
  output logic             o_done
);

  logic [Width-1:0] r_sr;
  logic [CntW-1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_data;
      r_cnt <= i_count;
    end else if (i_shift && (r_cnt != '0)) begin
      r_sr  <= {r_sr[Width-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_bit  = r_sr[Width-1];
  assign o_last = (r_cnt == CntW'(1));
  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/tx_packetizer.sv
// Frame assembler: preamble, 16-bit BPSK header {mode, len[14:0]}, payload symbols,
// then an idle gap, with a one-cycle pkt_sent pulse back to the source.
module tx_packetizer
  import tx_packetizer_pkg::*;
#(
  parameter int unsigned BYTES        = 1,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter logic [31:0] PREAMBLE_PAT = 32'hF35A_0C9D,
  parameter int unsigned GAP_LEN      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_enable,
  input  logic [BYTES*8-1:0] s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  input  logic               s_tuser,
  input  logic [15:0]        payload_length,
  output logic [1:0]         m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               m_tuser,
  output logic               pkt_sent,
  output logic               busy,
  output logic               err_early_last,
  output logic               err_underrun
);

  localparam logic [5:0]  PreCnt  = 6'(PREAMBLE_LEN);
  localparam logic [5:0]  HdrCnt  = 6'(HDR_LEN);
  // GAP always lasts at least the pkt_sent cycle.
  localparam logic [16:0] GapEnd  = (GAP_LEN == 0) ? 17'd1 : 17'(GAP_LEN);

  tx_state_e   r_state, w_state_d;
  logic        r_mode, w_mode_d;
  logic [14:0] r_len, w_len_d;
  logic [15:0] r_nsym, w_nsym_d;
  logic [15:0] r_sym_cnt, w_sym_cnt_d;
  logic [15:0] r_gap_cnt, w_gap_cnt_d;
  logic [1:0]  r_tdata, w_tdata_d;
  logic        r_tvalid, w_tvalid_d;
  logic        r_tlast, w_tlast_d;
  logic        r_tuser, w_tuser_d;
  logic        r_pkt_sent, w_pkt_sent_d;
  logic        r_err_early, w_err_early_d;
  logic        r_err_under, w_err_under_d;

  logic        w_sh_load, w_sh_shift, w_sh_bit, w_sh_last, w_sh_done;
  logic [31:0] w_sh_data;
  logic [5:0]  w_sh_count;
  logic        w_load, w_hs_last, w_sready, w_accept, w_word_last;
  logic        w_unused_tdata;

  assign w_unused_tdata = ^s_tdata;

  tx_frame_bit_shifter #(
    .Width (32),
    .CntW  (6)
  ) u_shifter (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_sh_load),
    .i_data  (w_sh_data),
    .i_count (w_sh_count),
    .i_shift (w_sh_shift),
    .o_bit   (w_sh_bit),
    .o_last  (w_sh_last),
    .o_done  (w_sh_done)
  );

  assign w_load      = !r_tvalid || m_tready;
  assign w_hs_last   = r_tvalid && m_tready && r_tlast;
  assign w_sready    = clk_enable && (r_state == StPayload) && w_load && (r_sym_cnt != r_nsym);
  assign w_accept    = w_sready && s_tvalid;
  assign w_word_last = ((r_sym_cnt + 16'd1) == r_nsym);

  always_comb begin
    w_state_d     = r_state;
    w_mode_d      = r_mode;
    w_len_d       = r_len;
    w_nsym_d      = r_nsym;
    w_sym_cnt_d   = r_sym_cnt;
    w_gap_cnt_d   = r_gap_cnt;
    w_tdata_d     = r_tdata;
    w_tvalid_d    = r_tvalid;
    w_tlast_d     = r_tlast;
    w_tuser_d     = r_tuser;
    w_pkt_sent_d  = r_pkt_sent;
    w_err_early_d = r_err_early;
    w_err_under_d = r_err_under;
    w_sh_load     = 1'b0;
    w_sh_shift    = 1'b0;
    w_sh_data     = '0;
    w_sh_count    = '0;

    if (clk_enable) begin
      w_pkt_sent_d = 1'b0;
      // A taken symbol empties the slot unless something reloads it below.
      if (r_tvalid && m_tready) begin
        w_tvalid_d = 1'b0;
        w_tlast_d  = 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (s_tvalid) begin
            w_mode_d    = s_tuser;
            w_len_d     = payload_length[14:0];
            w_nsym_d    = calc_nsym(s_tuser, payload_length);
            w_sym_cnt_d = '0;
            w_sh_load   = 1'b1;
            w_sh_data   = PREAMBLE_PAT;
            w_sh_count  = PreCnt;
            w_state_d   = StPreamble;
          end
        end
        StPreamble: begin
          if (w_load) begin
            w_tdata_d  = {w_sh_bit, w_sh_bit};
            w_tuser_d  = 1'b1;
            w_tlast_d  = 1'b0;
            w_tvalid_d = 1'b1;
            if (w_sh_last) begin
              w_sh_load  = 1'b1;
              w_sh_data  = {r_mode, r_len, 16'h0000};
              w_sh_count = HdrCnt;
              w_state_d  = StHeader;
            end else begin
              w_sh_shift = 1'b1;
            end
          end
        end
        StHeader: begin
          if (w_hs_last) begin
            w_state_d    = StGap;
            w_gap_cnt_d  = '0;
            w_pkt_sent_d = 1'b1;
          end else if (w_load && !w_sh_done) begin
            w_tdata_d  = {w_sh_bit, w_sh_bit};
            w_tuser_d  = 1'b1;
            w_tlast_d  = w_sh_last && (r_nsym == '0);
            w_tvalid_d = 1'b1;
            w_sh_shift = 1'b1;
            if (w_sh_last && (r_nsym != '0)) begin
              w_state_d = StPayload;
            end
          end
        end
        StPayload: begin
          if (w_hs_last) begin
            w_state_d    = StGap;
            w_gap_cnt_d  = '0;
            w_pkt_sent_d = 1'b1;
          end else if (w_accept) begin
            w_tdata_d   = s_tdata[1:0];
            w_tuser_d   = s_tuser;
            w_tlast_d   = w_word_last;
            w_tvalid_d  = 1'b1;
            w_sym_cnt_d = r_sym_cnt + 16'd1;
            if (s_tlast && !w_word_last) begin
              w_err_early_d = 1'b1;
            end
          end
          if (!s_tvalid && (r_sym_cnt != r_nsym)) begin
            w_err_under_d = 1'b1;
          end
        end
        StGap: begin
          if (({1'b0, r_gap_cnt} + 17'd1) >= GapEnd) begin
            w_state_d = StIdle;
          end else begin
            w_gap_cnt_d = r_gap_cnt + 16'd1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_mode      <= 1'b0;
      r_len       <= '0;
      r_nsym      <= '0;
      r_sym_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_pkt_sent  <= 1'b0;
      r_err_early <= 1'b0;
      r_err_under <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_mode      <= w_mode_d;
      r_len       <= w_len_d;
      r_nsym      <= w_nsym_d;
      r_sym_cnt   <= w_sym_cnt_d;
      r_gap_cnt   <= w_gap_cnt_d;
      r_tdata     <= w_tdata_d;
      r_tvalid    <= w_tvalid_d;
      r_tlast     <= w_tlast_d;
      r_tuser     <= w_tuser_d;
      r_pkt_sent  <= w_pkt_sent_d;
      r_err_early <= w_err_early_d;
      r_err_under <= w_err_under_d;
    end
  end

  assign s_tready       = w_sready;
  assign m_tdata        = r_tdata;
  assign m_tvalid       = r_tvalid;
  assign m_tlast        = r_tlast;
  assign m_tuser        = r_tuser;
  assign pkt_sent       = r_pkt_sent;
  assign busy           = (r_state != StIdle);
  assign err_early_last = r_err_early;
  assign err_underrun   = r_err_under;

endmodule

// File: tb/tb_tx_packetizer.sv
// Randomised self-checking bench: each frame's expected symbol list is built from the
// frame rules (preamble bits, header word, payload words) and compared per handshake.
module tb_tx_packetizer;
  import tx_packetizer_pkg::*;

  localparam int PreLen = 32;
  localparam int GapLen = 16;
  localparam int Limit  = 4000;

  logic       clk = 1'b0;
  logic       rst, clk_enable, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [7:0] s_tdata;
  logic [15:0] payload_length;
  logic [1:0] m_tdata;
  logic       m_tvalid, m_tready, m_tlast, m_tuser, pkt_sent, busy;
  logic       err_early_last, err_underrun;

  always #5 clk = ~clk;

  tx_packetizer #(
    .BYTES        (1),
    .PREAMBLE_LEN (PreLen),
    .PREAMBLE_PAT (32'hF35A_0C9D),
    .GAP_LEN      (GapLen)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_enable     (clk_enable),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .s_tlast        (s_tlast),
    .s_tuser        (s_tuser),
    .payload_length (payload_length),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tlast        (m_tlast),
    .m_tuser        (m_tuser),
    .pkt_sent       (pkt_sent),
    .busy           (busy),
    .err_early_last (err_early_last),
    .err_underrun   (err_underrun)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_q[$];
  logic [7:0] src_d_q[$];
  bit         src_u_q[$];
  bit         src_l_q[$];
  bit         mdl_early, mdl_under;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({s_tready, m_tvalid, m_tdata, m_tlast, m_tuser, pkt_sent, busy,
                err_early_last, err_underrun});
  endfunction

  task automatic flush_model();
    exp_q.delete();
    src_d_q.delete();
    src_u_q.delete();
    src_l_q.delete();
    mdl_early = 1'b0;
    mdl_under = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clk_enable = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    @(negedge clk);
    #1;
    check_eq("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    flush_model();
  endtask

  task automatic mid_reset();
    bit seen;
    @(negedge clk);
    rst = 1'b1; clk_enable = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("midframe_reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (GapLen + 8) begin
      @(negedge clk);
      #1;
      if (pkt_sent || busy) seen = 1'b1;
    end
    check_eq("midframe_reset_quiet", 32'(seen), 32'd0);
    flush_model();
  endtask

  // rdy_pat: 0 always ready, 1 toggling, 2 random. en_pat: 0 full rate, 1 one cycle in four.
  task automatic run_frame(input bit mode, input int len, input int rdy_pat, input int en_pat,
                           input int early_idx, input int under_at, input int rst_at,
                           input bit flip);
    int nsym, total, cyc, got, popped, sent, gapc, drop_cnt;
    bit done, started, after_last, bubble, hold_pend, drop, en;
    logic [15:0] lenv, hdr;
    logic [31:0] pat;
    logic [7:0]  d;
    bit          u;
    logic [3:0]  cur, e;
    logic [4:0]  hold_val;
    lenv = len[15:0];
    nsym = mode ? len : len / 2;
    total = PreLen + int'(HDR_LEN) + nsym;
    pat = 32'hF35A_0C9D;
    hdr = {mode, lenv[14:0]};
    for (int k = 0; k < PreLen; k++) exp_q.push_back({1'b0, 1'b1, pat[31-k], pat[31-k]});
    for (int k = 0; k < 16; k++)
      exp_q.push_back({1'(nsym == 0 && k == 15), 1'b1, hdr[15-k], hdr[15-k]});
    for (int i = 0; i < nsym; i++) begin
      d = (i == 0) ? 8'hFE : 8'($urandom);
      u = (flip && i > 0 && $urandom_range(0, 3) == 0) ? !mode : mode;
      src_d_q.push_back(d);
      src_u_q.push_back(u);
      src_l_q.push_back(i == nsym - 1 || i == early_idx);
      exp_q.push_back({1'(i == nsym - 1), u, d[1:0]});
    end
    if (early_idx >= 0 && early_idx != nsym - 1) mdl_early = 1'b1;
    if (under_at >= 0) mdl_under = 1'b1;

    cyc = 0; got = 0; popped = 0; sent = 0; gapc = 0; drop_cnt = 0;
    done = 0; started = 0; after_last = 0; bubble = 0; hold_pend = 0; hold_val = '0;
    while (!done && cyc < Limit) begin
      @(negedge clk);
      en = (en_pat == 0) || (cyc % 4 == 0);
      drop = (under_at >= 0) && (popped == under_at) && (drop_cnt < 5);
      clk_enable = en;
      m_tready = (rdy_pat == 0) ? 1'b1 : (rdy_pat == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      payload_length = lenv;
      if (src_d_q.size() > 0 && !drop) begin
        s_tvalid = 1'b1; s_tdata = src_d_q[0]; s_tuser = src_u_q[0]; s_tlast = src_l_q[0];
      end else begin
        s_tvalid = (nsym == 0) && !started; s_tdata = 8'h00; s_tuser = mode; s_tlast = 1'b0;
      end
      #1;
      cur = {m_tlast, m_tuser, m_tdata};
      if (hold_pend) check_eq("stall_hold", 32'({m_tvalid, cur}), 32'(hold_val));
      if (!en) check_eq("ready_when_disabled", 32'(s_tready), 32'd0);
      if (busy) started = 1'b1;
      if (en) begin
        if (after_last) begin
          if (busy) gapc++;
          else done = 1'b1;
        end
        if (pkt_sent) sent++;
        hold_pend = m_tvalid && !m_tready;
        hold_val = {m_tvalid, cur};
        if (drop) drop_cnt++;
        if (m_tvalid && m_tready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
          check_eq($sformatf("symbol_%0d", got), 32'(cur), 32'(e));
          got++;
          if (got == total) after_last = 1'b1;
        end else if (!m_tvalid && got > 0 && got < total) begin
          bubble = 1'b1;
        end
        if (s_tvalid && s_tready) begin
          if (src_d_q.size() > 0) begin
            void'(src_d_q.pop_front());
            void'(src_u_q.pop_front());
            void'(src_l_q.pop_front());
          end
          popped++;
        end
        if (rst_at > 0 && got == rst_at) begin
          mid_reset();
          return;
        end
      end
      cyc++;
    end
    s_tvalid = 1'b0;
    check_eq("frame_done_in_budget", 32'(done), 32'd1);
    if (!done) begin
      do_reset();
      return;
    end
    check_eq("symbol_count", 32'(got), 32'(total));
    check_eq("pkt_sent_cycles", 32'(sent), 32'd1);
    check_eq("gap_cycles", 32'(gapc), (GapLen == 0) ? 32'd1 : 32'(GapLen));
    check_eq("err_early_last", 32'(err_early_last), 32'(mdl_early));
    check_eq("err_underrun", 32'(err_underrun), 32'(mdl_under));
    check_eq("bubble_seen", 32'(bubble), 32'(under_at >= 0));
    check_eq("queues_drained", 32'(exp_q.size() + src_d_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; clk_enable = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    s_tuser = 1'b0; payload_length = '0; m_tready = 1'b0;
    flush_model();
    do_reset();
    run_frame(1'b1, 128, 0, 0, -1, -1, -1, 1'b0);
    run_frame(1'b1, $urandom_range(1, 40), 0, 0, -1, -1, -1, 1'b0);
    run_frame(1'b0, 128, 0, 0, -1, -1, -1, 1'b0);
    run_frame(1'b0, 129, 0, 0, -1, -1, -1, 1'b0);
    run_frame(1'b1, 128, 1, 0, -1, -1, -1, 1'b0);
    run_frame(1'b1, 128, 0, 1, -1, -1, -1, 1'b0);
    do_reset();
    run_frame(1'b1, 128, 0, 0, 99, -1, -1, 1'b0);
    do_reset();
    run_frame(1'b1, 128, 0, 0, -1, 60, -1, 1'b0);
    do_reset();
    run_frame(1'b1, 0, 0, 0, -1, -1, -1, 1'b0);
    run_frame(1'b0, 1, 0, 0, -1, -1, -1, 1'b0);
    run_frame(1'b1, 128, 0, 0, -1, -1, 40, 1'b0);
    repeat (6) begin
      run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 40), 2, $urandom_range(0, 1),
                -1, -1, -1, 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
